// File: rtl/conv_pkg.sv
// Shared types and default constants for the convolution accumulator unit.
// The ReLU clamp is enabled by defining CONV_UNIT_ACC_RELU_EN when building conv_unit_acc.
package conv_pkg;

    // Job sequencing states
    typedef enum logic [2:0] {
        StIdle    = 3'd0,
        StAccum   = 3'd1,
        StDrain   = 3'd2,
        StRequant = 3'd3,
        StOutput  = 3'd4
    } conv_state_e;

    // Default widths and array sizes
    localparam int unsigned DefMacInNum     = 9;
    localparam int unsigned DefMacOutNum    = 18;
    localparam int unsigned DefDataWidth    = 8;
    localparam int unsigned DefWeightWidth  = 8;
    localparam int unsigned DefBiasWidth    = 16;
    localparam int unsigned DefAccWidth     = 32;
    localparam int unsigned DefTileCntWidth = 8;
    localparam int unsigned DefScaleWidth   = 5;

    // Signed saturation limits for a w-bit output
    function automatic int sat_max(int unsigned w);
        return (1 << (w - 1)) - 1;
    endfunction

    function automatic int sat_min(int unsigned w);
        return -(1 << (w - 1));
    endfunction

    localparam int DefSatMax = sat_max(DefDataWidth);
    localparam int DefSatMin = sat_min(DefDataWidth);

endpackage

// File: rtl/mac_dot.sv
// One output channel: signed products of a data beat with its weight row, summed and registered.
module mac_dot
    import conv_pkg::*;
#(
    parameter int unsigned MAC_IN_NUM   = DefMacInNum,
    parameter int unsigned DATA_WIDTH   = DefDataWidth,
    parameter int unsigned WEIGHT_WIDTH = DefWeightWidth,
    parameter int unsigned ACC_WIDTH    = DefAccWidth
) (
    input  logic                                 clk_i,
    input  logic                                 rst_i,
    input  logic                                 en_i,
    input  logic [MAC_IN_NUM*DATA_WIDTH-1:0]     data_i,
    input  logic [MAC_IN_NUM*WEIGHT_WIDTH-1:0]   weight_i,
    output logic signed [ACC_WIDTH-1:0]          dot_o
);

    localparam int unsigned ProdWidth = DATA_WIDTH + WEIGHT_WIDTH;

    logic signed [ProdWidth-1:0] prod [MAC_IN_NUM];
    logic signed [ACC_WIDTH-1:0] dot_d, dot_q;

    // Products and their sum; the linear sum is left for synthesis to balance
    always_comb begin
        dot_d = '0;
        for (int i = 0; i < MAC_IN_NUM; i++) begin
            prod[i] = ProdWidth'($signed(data_i[i*DATA_WIDTH +: DATA_WIDTH])) *
                      ProdWidth'($signed(weight_i[i*WEIGHT_WIDTH +: WEIGHT_WIDTH]));
            dot_d   = dot_d + ACC_WIDTH'(prod[i]);
        end
    end

    // Pipeline register, loaded only on an accepted beat
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            dot_q <= '0;
        end else if (en_i) begin
            dot_q <= dot_d;
        end
    end

    assign dot_o = dot_q;

endmodule

// File: rtl/conv_unit_acc.sv
// Convolution accumulator: per-channel dot products over tile_num beats, bias preload,
// rounding right shift and saturation to DATA_WIDTH. Optional macro CONV_UNIT_ACC_RELU_EN
// clamps negative results to zero.
module conv_unit_acc
    import conv_pkg::*;
#(
    parameter int unsigned MAC_IN_NUM     = DefMacInNum,
    parameter int unsigned MAC_OUT_NUM    = DefMacOutNum,
    parameter int unsigned DATA_WIDTH     = DefDataWidth,
    parameter int unsigned WEIGHT_WIDTH   = DefWeightWidth,
    parameter int unsigned BIAS_WIDTH     = DefBiasWidth,
    parameter int unsigned ACC_WIDTH      = DefAccWidth,
    parameter int unsigned TILE_CNT_WIDTH = DefTileCntWidth,
    parameter int unsigned SCALE_WIDTH    = DefScaleWidth
) (
    input  logic                                        clk,
    input  logic                                        rst,
    input  logic                                        cfg_valid,
    input  logic [TILE_CNT_WIDTH-1:0]                   cfg_tile_num,
    input  logic [SCALE_WIDTH-1:0]                      cfg_scale,
    input  logic [MAC_IN_NUM*WEIGHT_WIDTH*MAC_OUT_NUM-1:0] weight_in,
    input  logic                                        weight_valid,
    input  logic [BIAS_WIDTH*MAC_OUT_NUM-1:0]           bias_in,
    input  logic [MAC_IN_NUM*DATA_WIDTH-1:0]            data_in,
    input  logic                                        data_valid,
    output logic                                        data_ready,
    output logic [MAC_OUT_NUM*DATA_WIDTH-1:0]           out_data,
    output logic                                        out_valid,
    input  logic                                        out_ready,
    output logic                                        busy,
    output logic                                        done
);

    localparam int unsigned RowWidth = MAC_IN_NUM * WEIGHT_WIDTH;
    localparam int unsigned WgtWidth = RowWidth * MAC_OUT_NUM;

    localparam logic signed [ACC_WIDTH:0] SatMax = (ACC_WIDTH + 1)'(sat_max(DATA_WIDTH));
    localparam logic signed [ACC_WIDTH:0] SatMin = (ACC_WIDTH + 1)'(sat_min(DATA_WIDTH));

`ifdef CONV_UNIT_ACC_RELU_EN
    localparam bit ReluEn = 1'b1;
`else
    localparam bit ReluEn = 1'b0;
`endif

    conv_state_e                      state_q, state_d;
    logic [TILE_CNT_WIDTH-1:0]        tile_q, tile_d;
    logic [TILE_CNT_WIDTH-1:0]        cnt_q, cnt_d, cnt_inc;
    logic [SCALE_WIDTH-1:0]           scale_q, scale_d;
    logic [WgtWidth-1:0]              weight_q, weight_d;
    logic                             pipe_vld_q, pipe_vld_d;
    logic signed [ACC_WIDTH-1:0]      acc_q [MAC_OUT_NUM];
    logic signed [ACC_WIDTH-1:0]      acc_d [MAC_OUT_NUM];
    logic signed [ACC_WIDTH-1:0]      dot   [MAC_OUT_NUM];
    logic [MAC_OUT_NUM*DATA_WIDTH-1:0] out_data_q, out_data_d, rq_data;
    logic signed [ACC_WIDTH:0]        ext, half, shf;
    logic [DATA_WIDTH-1:0]            res;
    logic                             beat;

    assign data_ready = (state_q == StAccum);
    assign beat       = data_valid && data_ready;
    assign out_valid  = (state_q == StOutput);
    assign busy       = (state_q != StIdle);
    assign done       = out_valid && out_ready;
    assign out_data   = out_data_q;
    assign cnt_inc    = cnt_q + TILE_CNT_WIDTH'(1);

    // One dot-product pipeline per output channel, all fed the same beat
    for (genvar o = 0; o < MAC_OUT_NUM; o++) begin : g_mac
        mac_dot #(
            .MAC_IN_NUM   (MAC_IN_NUM),
            .DATA_WIDTH   (DATA_WIDTH),
            .WEIGHT_WIDTH (WEIGHT_WIDTH),
            .ACC_WIDTH    (ACC_WIDTH)
        ) u_mac_dot (
            .clk_i    (clk),
            .rst_i    (rst),
            .en_i     (beat),
            .data_i   (data_in),
            .weight_i (weight_q[o*RowWidth +: RowWidth]),
            .dot_o    (dot[o])
        );
    end

    // Round-half-up shift and saturate; extra MSB keeps the rounding add from overflowing
    always_comb begin
        rq_data = '0;
        ext     = '0;
        half    = '0;
        shf     = '0;
        res     = '0;
        for (int o = 0; o < MAC_OUT_NUM; o++) begin
            ext  = {acc_q[o][ACC_WIDTH-1], acc_q[o]};
            half = (scale_q == '0) ? '0 : ((ACC_WIDTH + 1)'(1) << (scale_q - SCALE_WIDTH'(1)));
            shf  = (ext + half) >>> scale_q;
            if (shf > SatMax) begin
                res = SatMax[DATA_WIDTH-1:0];
            end else if (shf < SatMin) begin
                res = SatMin[DATA_WIDTH-1:0];
            end else begin
                res = shf[DATA_WIDTH-1:0];
            end
            if (ReluEn && shf[ACC_WIDTH]) begin
                res = '0;
            end
            rq_data[o*DATA_WIDTH +: DATA_WIDTH] = res;
        end
    end

    // Next-state: job sequencing, accumulation one cycle behind each beat, weight loads
    always_comb begin
        state_d    = state_q;
        tile_d     = tile_q;
        scale_d    = scale_q;
        cnt_d      = cnt_q;
        weight_d   = weight_valid ? weight_in : weight_q;
        pipe_vld_d = beat;
        out_data_d = out_data_q;
        for (int o = 0; o < MAC_OUT_NUM; o++) begin
            acc_d[o] = pipe_vld_q ? (acc_q[o] + dot[o]) : acc_q[o];
        end

        unique case (state_q)
            StIdle: begin
                if (cfg_valid) begin
                    tile_d  = cfg_tile_num;
                    scale_d = cfg_scale;
                    cnt_d   = '0;
                    for (int o = 0; o < MAC_OUT_NUM; o++) begin
                        acc_d[o] = ACC_WIDTH'($signed(bias_in[o*BIAS_WIDTH +: BIAS_WIDTH]));
                    end
                    state_d = (cfg_tile_num == '0) ? StDrain : StAccum;
                end
            end
            StAccum: begin
                if (beat) begin
                    cnt_d = cnt_inc;
                    if (cnt_inc == tile_q) begin
                        state_d = StDrain;
                    end
                end
            end
            // Last product lands in the accumulators during this cycle
            StDrain: begin
                state_d = StRequant;
            end
            StRequant: begin
                out_data_d = rq_data;
                state_d    = StOutput;
            end
            StOutput: begin
                if (out_ready) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State and datapath registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            tile_q     <= '0;
            scale_q    <= '0;
            cnt_q      <= '0;
            weight_q   <= '0;
            pipe_vld_q <= 1'b0;
            out_data_q <= '0;
            for (int o = 0; o < MAC_OUT_NUM; o++) begin
                acc_q[o] <= '0;
            end
        end else begin
            state_q    <= state_d;
            tile_q     <= tile_d;
            scale_q    <= scale_d;
            cnt_q      <= cnt_d;
            weight_q   <= weight_d;
            pipe_vld_q <= pipe_vld_d;
            out_data_q <= out_data_d;
            for (int o = 0; o < MAC_OUT_NUM; o++) begin
                acc_q[o] <= acc_d[o];
            end
        end
    end

endmodule

// File: doc/conv_unit_acc.md
CONV_UNIT_ACC -- requirements
Module: conv_unit_acc

Interface
REQ-001 SHALL have parameter MAC_IN_NUM, default 9, inputs per output channel dot product.
REQ-002 SHALL have parameter MAC_OUT_NUM, default 18, parallel output channels.
REQ-003 SHALL have parameters DATA_WIDTH 8, WEIGHT_WIDTH 8, BIAS_WIDTH 16, ACC_WIDTH 32, TILE_CNT_WIDTH 8, SCALE_WIDTH 5, all signed two's-complement widths.
REQ-004 SHALL use one clock; reset is synchronous and active-high.
REQ-005 clk  in  1  rising-edge clock.
REQ-006 rst  in  1  synchronous active-high reset.
REQ-007 cfg_valid  in  1, plus cfg_tile_num in TILE_CNT_WIDTH and cfg_scale in SCALE_WIDTH: job start, beat count, right-shift amount.
REQ-008 weight_in  in  MAC_IN_NUM*WEIGHT_WIDTH*MAC_OUT_NUM, with weight_valid in 1: weight matrix load.
REQ-009 bias_in  in  BIAS_WIDTH*MAC_OUT_NUM  per-channel bias, sampled on the cfg_valid acceptance cycle.
REQ-010 data_in  in  MAC_IN_NUM*DATA_WIDTH, data_valid in 1, data_ready out 1: input beat handshake.
REQ-011 out_data  out  MAC_OUT_NUM*DATA_WIDTH, out_valid out 1, out_ready in 1: result handshake.
REQ-012 busy  out  1 (state != IDLE); done  out  1 (one-cycle pulse on result handshake).

Function
REQ-013 SHALL implement states IDLE, ACCUM, DRAIN, REQUANT, OUTPUT.
REQ-014 IDLE: cfg_valid=1 latches tile_num/scale, loads each accumulator with the sign-extended bias, and moves to ACCUM, or to DRAIN if cfg_tile_num==0.
REQ-015 cfg_valid outside IDLE SHALL be ignored.
REQ-016 data_ready SHALL be 1 only in ACCUM; a beat is data_valid&&data_ready; beats outside ACCUM are ignored.
REQ-017 Each beat SHALL compute per channel sum(data_i*weight_i) signed, register it (1 stage), and add it to the ACC_WIDTH accumulator one cycle later.
REQ-018 After tile_num beats, ACCUM SHALL go to DRAIN for 1 cycle, then REQUANT for 1 cycle, then OUTPUT; out_valid SHALL rise 3 cycles after the last beat.
REQ-019 Requantisation: scale==0 passes acc unchanged; scale>0 computes (acc + 2^(scale-1)) arithmetically shifted right by scale; result is saturated to [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1].
REQ-020 OUTPUT: out_valid=1 and out_data stable until out_ready; on handshake, done pulses and the state returns to IDLE.
REQ-021 weight_valid SHALL update the weight register in any state; a beat in the same cycle uses the old weights.
REQ-022 Accumulator overflow SHALL wrap; with defaults, ACC_WIDTH is sized so that overflow is unreachable for tile_num<=255.

Reset
REQ-023 rst SHALL force IDLE and clear the accumulators, weight register, pipeline register and beat counter; out_data, out_valid, data_ready, busy and done SHALL all be 0 the cycle after.
REQ-024 rst mid-job SHALL abandon the job with no out_valid or done; the next job SHALL be unaffected.

Configuration
REQ-025 Macro CONV_UNIT_ACC_RELU_EN defined: negative requantised results output as 0. Undefined: signed saturated results are output unchanged.

Structure
REQ-026 Package conv_pkg SHALL hold the state encoding, the default width constants, and the saturation limit constants.
REQ-027 Sub-module mac_dot (one channel: products, adder tree, pipeline register) SHALL be instantiated MAC_OUT_NUM times.

Verification
REQ-028 tile_num=1, scale=0, bias=0, all data=1, all weights=1 -> every channel outputs 9; out_valid appears 3 cycles after the beat.
REQ-029 tile_num=3, data=2, weight=3, bias=5, scale=2 -> acc=167, out=42 on every channel.
REQ-030 tile_num=4, data=127, weight=127, scale=0 -> out=127; weight=-128 -> out=-128, or 0 with CONV_UNIT_ACC_RELU_EN.
REQ-031 tile_num=0, bias=-12, scale=1 -> out=-6, no beat accepted (data_ready never 1).
REQ-032 out_ready held low 5 cycles -> out_valid and out_data stable, data_ready=0, done pulses once on the handshake cycle.
REQ-033 rst asserted in ACCUM after 2 of 4 beats -> IDLE next cycle, no out_valid; the following job (REQ-028 stimulus) outputs 9.
